// File: rtl/ps2_frame_receiver_if.sv
// PS/2 receiver bus bundle: raw PS/2 lines and enable in, byte-pop handshake and status out.
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       samplen;
    logic       rden;
    logic [7:0] q;
    logic       dsr;
    logic       overflow;
    logic       parerr;

    modport master (
        output ps2_clk, ps2_data, samplen, rden,
        input  q, dsr, overflow, parerr
    );

    modport slave (
        input  ps2_clk, ps2_data, samplen, rden,
        output q, dsr, overflow, parerr
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// Device-to-host PS/2 receiver: sync + glitch filter, 11-bit frame deframer with odd parity
// check, and a small byte FIFO popped through the q/dsr/rden interface.

// Two-flop synchronizer preset to the idle-bus level.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], din};
    end

    assign dout = sync[1];
endmodule

module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DEPTH_LOG2     = 3
) (
    input logic                  clk,
    input logic                  reset,
    ps2_frame_receiver_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ---------------- input path ----------------
    logic [1:0] line_raw, line_sync;
    assign line_raw = {bus.ps2_data, bus.ps2_clk};

    for (genvar i = 0; i < 2; i++) begin : g_sync
        ps2_line_sync u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (line_raw[i]),
            .dout (line_sync[i])
        );
    end

    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          fall;
    logic          din;

    // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (line_sync[0] != filt) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    filt <= ~filt;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall = filt_d & ~filt;
    assign din  = line_sync[1];

    // ---------------- deframer ----------------
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          push_vld;
    logic          parerr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tcnt     <= '0;
            push_vld <= 1'b0;
            parerr_r <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            parerr_r <= 1'b0;
            if (!bus.samplen) begin
                // Host owns the bus: drop any partial frame, filters keep tracking.
                state <= S_IDLE;
                tcnt  <= '0;
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!din) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg  <= {din, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= din;
                        state   <= S_STOP;
                    end
                    default: begin
                        if (din && (^{shreg, par_bit})) push_vld <= 1'b1;
                        else                            parerr_r <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end else if (state == S_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= S_IDLE;
                tcnt  <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count, count_next;
    logic [7:0]            q_r;
    logic                  dsr_r, overflow_r;
    logic                  full, do_pop, do_push, drop;

    // count never exceeds DEPTH, so its MSB alone marks full.
    assign full    = count[DEPTH_LOG2];
    assign do_pop  = bus.rden & dsr_r;
    assign do_push = push_vld & (~full | do_pop);
    assign drop    = push_vld & full & ~do_pop;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)      count_next = count + 1'b1;
        else if (!do_push && do_pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            q_r        <= '0;
            dsr_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                q_r    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            dsr_r <= (count_next != '0);
            if (drop) overflow_r <= 1'b1;
        end
    end

    assign bus.q        = q_r;
    assign bus.dsr      = dsr_r;
    assign bus.overflow = overflow_r;
    assign bus.parerr   = parerr_r;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed + randomized bench for ps2_frame_receiver against a queue-based byte model.
module tb_ps2_frame_receiver;
    localparam int FL = 8;
    localparam int TO = 300;
    localparam int DL = 3;
    localparam int HP = 20;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_frame_receiver_if bus();

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DEPTH_LOG2(DL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int parerr_seen = 0;
    byte unsigned model[$];
    bit model_ovf;
    logic [7:0] last_q;

    always @(posedge clk) if (bus.parerr === 1'b1) parerr_seen <= parerr_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Device-side frame: data changes while clock high, sampled on the falling edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                              input int nbits = 11, input bit glitch = 0,
                              input bit pop_on_push = 0, input bit mask = 0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            bus.ps2_data = f[k];
            if (mask) bus.samplen = !(k >= 2 && k <= 6);
            for (int i = 0; i < HP; i++) begin
                bus.ps2_clk = !(glitch && k == 3 && i >= 13 && i < 16);
                tick(1);
            end
            for (int i = 0; i < HP; i++) begin
                bus.ps2_clk = (glitch && k == 5 && i >= 14 && i < 17);
                if (pop_on_push && k == 10) bus.rden = (i == 11);
                tick(1);
            end
        end
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rden     = 1'b0;
        bus.samplen  = 1'b1;
        tick(2 * HP);
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (model.size() < DEPTH) model.push_back(b);
        else                      model_ovf = 1'b1;
    endfunction

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = (model.size() != 0) ? model.pop_front() : last_q;
        bus.rden = 1'b1;
        tick(1);
        bus.rden = 1'b0;
        check(tag, bus.q, exp);
        check({tag, "_dsr"}, bus.dsr, model.size() != 0);
        last_q = exp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model.delete();
        model_ovf = 1'b0;
        last_q = 8'h00;
    endtask

    initial begin
        int p0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.samplen = 1'b1;
        bus.rden = 1'b0;
        do_reset();
        check("rst_q", bus.q, 8'h00);
        check("rst_dsr", bus.dsr, 1'b0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_parerr", bus.parerr, 1'b0);

        // basic frame
        send_frame(8'h1C);
        model_push(8'h1C);
        check("1c_dsr", bus.dsr, 1'b1);
        pop_check("1c_q");

        // parity error and stop-bit error
        p0 = parerr_seen;
        send_frame(8'hF0, 1'b1);
        check("par_pulses", parerr_seen - p0, 1);
        check("par_dsr", bus.dsr, 1'b0);
        p0 = parerr_seen;
        send_frame(8'h3C, 1'b0, 1'b1);
        check("stop_pulses", parerr_seen - p0, 1);
        check("stop_dsr", bus.dsr, 1'b0);

        // timeout after start + 5 data bits
        p0 = parerr_seen;
        send_frame(8'hFF, 1'b0, 1'b0, 6);
        tick(TO + 10);
        send_frame(8'h5A);
        model_push(8'h5A);
        check("to_parerr", parerr_seen - p0, 0);
        pop_check("to_5a");

        // samplen low during bits 2-6, device abandons the frame
        send_frame(8'h00, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b1);
        check("sam_dsr", bus.dsr, 1'b0);
        send_frame(8'h12);
        model_push(8'h12);
        pop_check("sam_12");

        // randomized traffic
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            bit bad, which;
            b = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            which = 1'($urandom);
            p0 = parerr_seen;
            send_frame(b, bad && which, bad && !which);
            if (!bad) model_push(b);
            check("rnd_parerr", parerr_seen - p0, bad ? 1 : 0);
            check("rnd_dsr", bus.dsr, model.size() != 0);
            repeat ($urandom_range(0, 2)) pop_check("rnd_pop");
        end
        while (model.size() != 0) pop_check("rnd_drain");
        check("rnd_ovf", bus.overflow, model_ovf);

        // overflow: 9 frames, no pops
        for (int n = 1; n <= 9; n++) begin
            send_frame(8'(n));
            model_push(8'(n));
        end
        check("ovf_flag", bus.overflow, 1'b1);
        for (int n = 0; n < DEPTH; n++) pop_check("ovf_pop");
        check("ovf_empty", bus.dsr, 1'b0);
        pop_check("empty_pop");

        // reset in the middle of a frame
        send_frame(8'hAA, 1'b0, 1'b0, 4);
        do_reset();
        check("mid_rst_q", bus.q, 8'h00);
        check("mid_rst_dsr", bus.dsr, 1'b0);
        check("mid_rst_ovf", bus.overflow, 1'b0);

        // full FIFO, glitchy clock, pop coinciding with push
        for (int n = 1; n <= DEPTH; n++) begin
            send_frame(8'(n));
            model_push(8'(n));
        end
        check("fill_ovf", bus.overflow, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, 11, 1'b1, 1'b1);
        last_q = model.pop_front();
        model_push(8'h29);
        check("sim_q", bus.q, last_q);
        check("sim_ovf", bus.overflow, 1'b0);
        while (model.size() != 0) pop_check("sim_pop");
        check("sim_ovf_end", bus.overflow, model_ovf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
